oam_dma: RTL and testbench

//  NES sprite DMA unit on the CPU-side memory bus, directly downstream of cpu (consumes its

---
 rtl/nes_pkg.sv | 15 +
 rtl/oam_dma.sv | 99 +++++++++
 tb/tb_oam_dma.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
// Shared NES CPU-bus constants and the sprite DMA state encoding.
package nes_pkg;

    localparam logic [15:0] OAM_DMA_REG = 16'h4014;
    localparam logic [15:0] PPU_OAMDATA = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// NES sprite DMA: a CPU write to the DMA register halts the CPU and copies one
// 256-byte page into PPU OAMDATA; otherwise the CPU bus passes straight through.
module oam_dma
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = OAM_DMA_REG,
    parameter logic [15:0] OAM_DATA_ADDR = PPU_OAMDATA,
    parameter int unsigned XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_d_out,
    output logic        bus_we,
    input  logic [7:0]  bus_d_in,
    output logic        dma_busy
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t state;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] latch;
    logic       parity;

    // Transfer sequencing; parity keeps every READ on an even cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            page   <= 8'h00;
            idx    <= 8'h00;
            latch  <= 8'h00;
            parity <= 1'b0;
        end else begin
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
                        page  <= cpu_d_out;
                        idx   <= 8'h00;
                        state <= HALT;
                    end
                end
                HALT:  state <= parity ? READ : ALIGN;
                ALIGN: state <= READ;
                READ: begin
                    latch <= bus_d_in;
                    state <= WRITE;
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus mux: pass-through in IDLE, DMA owns the bus otherwise.
    always_comb begin
        bus_addr  = cpu_addr;
        bus_d_out = cpu_d_out;
        bus_we    = cpu_we;
        cpu_rdy   = 1'b1;
        dma_busy  = 1'b0;
        case (state)
            IDLE: ;
            HALT, ALIGN: begin
                bus_we   = 1'b0;
                cpu_rdy  = 1'b0;
                dma_busy = 1'b1;
            end
            READ: begin
                bus_addr = {page, idx};
                bus_we   = 1'b0;
                cpu_rdy  = 1'b0;
                dma_busy = 1'b1;
            end
            WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_d_out = latch;
                bus_we    = 1'b1;
                cpu_rdy   = 1'b0;
                dma_busy  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma with a flat memory model on the bus.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_we;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_d_out;
    logic        bus_we;
    logic [7:0]  bus_d_in;
    logic        dma_busy;

    oam_dma dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_d_out (cpu_d_out),
        .cpu_we    (cpu_we),
        .cpu_rdy   (cpu_rdy),
        .bus_addr  (bus_addr),
        .bus_d_out (bus_d_out),
        .bus_we    (bus_we),
        .bus_d_in  (bus_d_in),
        .dma_busy  (dma_busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [65536];
    assign bus_d_in = mem[bus_addr];

    int total = 0;
    int bad   = 0;

    logic        tb_par;
    logic [7:0]  wr_q [$];
    logic [15:0] rd_q [$];
    logic        par_q [$];
    int          rdy_low, cpu_leak, zero_acc, busy_mis;
    logic [15:0] prev_addr;
    logic        prev_par;

    // Memory image: page 2 holds i^A5, other pages a distinct pattern.
    function automatic logic [7:0] mem_val(input logic [15:0] a);
        if (a[15:8] == 8'h02) return a[7:0] ^ 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Reference parity: 0 in the first cycle after reset, toggling each clock.
    always @(posedge clk) tb_par <= rst ? 1'b0 : ~tb_par;

    // Bus observer, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (!cpu_rdy) rdy_low <= rdy_low + 1;
            if (dma_busy == cpu_rdy) busy_mis <= busy_mis + 1;
            if (dma_busy && bus_we && bus_addr == 16'h2004) begin
                wr_q.push_back(bus_d_out);
                rd_q.push_back(prev_addr);
                par_q.push_back(prev_par);
            end
            if (dma_busy && bus_we && bus_addr != 16'h2004) cpu_leak <= cpu_leak + 1;
            if (dma_busy && bus_addr == 16'h0000) zero_acc <= zero_acc + 1;
        end
        prev_addr <= bus_addr;
        prev_par  <= tb_par;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Trigger a transfer so that HALT lands on the requested parity.
    task automatic start(input logic [7:0] page, input logic want_halt_par, output int exp_low);
        for (int n = 0; n < 4 && tb_par != ~want_halt_par; n++) tick();
        wr_q.delete();
        rd_q.delete();
        par_q.delete();
        rdy_low  = 0;
        cpu_leak = 0;
        zero_acc = 0;
        busy_mis = 0;
        exp_low  = (tb_par == 1'b0) ? 513 : 514;
        cpu_addr  = 16'h4014;
        cpu_d_out = page;
        cpu_we    = 1'b1;
        tick();
        cpu_we    = 1'b0;
        cpu_d_out = 8'h00;
    endtask

    task automatic wait_done(input string tag);
        int n;
        for (n = 0; n < 1000; n++) begin
            tick();
            if (!dma_busy) break;
        end
        chk({tag, "_timeout"}, 32'(n < 1000), 32'd1);
        chk({tag, "_rdy_after"}, 32'(cpu_rdy), 32'd1);
    endtask

    task automatic check_xfer(input string tag, input logic [7:0] page, input int exp_low);
        int derr = 0;
        int aerr = 0;
        int perr = 0;
        int cnt = (wr_q.size() < 256) ? wr_q.size() : 256;
        chk({tag, "_nbytes"}, 32'(wr_q.size()), 32'd256);
        for (int i = 0; i < cnt; i++) begin
            if (wr_q[i] !== mem_val({page, 8'(i)})) derr++;
            if (rd_q[i] !== {page, 8'(i)}) aerr++;
            if (par_q[i] !== 1'b0) perr++;
        end
        chk({tag, "_data_errs"}, 32'(derr), 32'd0);
        chk({tag, "_rdaddr_errs"}, 32'(aerr), 32'd0);
        chk({tag, "_rdpar_errs"}, 32'(perr), 32'd0);
        chk({tag, "_rdy_low"}, 32'(rdy_low), 32'(exp_low));
        chk({tag, "_busy_vs_rdy"}, 32'(busy_mis), 32'd0);
        chk({tag, "_cpu_leak"}, 32'(cpu_leak), 32'd0);
    endtask

    initial begin
        int exp_low;
        for (int a = 0; a < 65536; a++) mem[a] = mem_val(16'(a));
        rdy_low = 0; cpu_leak = 0; zero_acc = 0; busy_mis = 0;
        rst = 1'b1;
        cpu_addr = 16'h0000;
        cpu_d_out = 8'h00;
        cpu_we = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // 1: reset state and pass-through
        chk("rst_rdy", 32'(cpu_rdy), 32'd1);
        chk("rst_busy", 32'(dma_busy), 32'd0);
        cpu_we = 1'b1; cpu_addr = 16'h8000; cpu_d_out = 8'h5A;
        #1;
        chk("pt_we", 32'(bus_we), 32'd1);
        chk("pt_addr", 32'(bus_addr), 32'h8000);
        chk("pt_data", 32'(bus_d_out), 32'h5A);
        chk("pt_rdy", 32'(cpu_rdy), 32'd1);
        tick();
        cpu_we = 1'b0;

        // 2: page 2, HALT on parity 1; trigger write passes through
        for (int n = 0; n < 4 && tb_par != 1'b0; n++) tick();
        cpu_addr = 16'h4014; cpu_d_out = 8'h02; cpu_we = 1'b1;
        #1;
        chk("trig_pt_we", 32'(bus_we), 32'd1);
        chk("trig_pt_addr", 32'(bus_addr), 32'h4014);
        start(8'h02, 1'b1, exp_low);
        chk("t2_exp513", 32'(exp_low), 32'd513);
        wait_done("t2");
        check_xfer("t2", 8'h02, exp_low);

        // back-to-back trigger on the first IDLE cycle
        start(8'h05, tb_par ? 1'b0 : 1'b1, exp_low);
        wait_done("b2b");
        check_xfer("b2b", 8'h05, exp_low);

        // 3: HALT on parity 0 needs one ALIGN cycle
        start(8'h02, 1'b0, exp_low);
        chk("t3_exp514", 32'(exp_low), 32'd514);
        wait_done("t3");
        check_xfer("t3", 8'h02, exp_low);

        // 4: page FF ends at $FFFF without wrapping
        start(8'hFF, 1'b1, exp_low);
        wait_done("t4");
        check_xfer("t4", 8'hFF, exp_low);
        chk("t4_last_rd", 32'(rd_q.size() == 256 ? rd_q[255] : 16'h0), 32'hFFFF);
        chk("t4_zero_acc", 32'(zero_acc), 32'd0);

        // 5: reset in READ of byte 100, then restart
        start(8'h03, 1'b1, exp_low);
        for (int n = 0; n < 400 && wr_q.size() < 100; n++) tick();
        chk("t5_at_read100", 32'(bus_addr), 32'h0364);
        chk("t5_read_we", 32'(bus_we), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_rdy", 32'(cpu_rdy), 32'd1);
        chk("t5_rst_busy", 32'(dma_busy), 32'd0);
        chk("t5_rst_we", 32'(bus_we), 32'd0);
        repeat (5) tick();
        chk("t5_no_more_wr", 32'(wr_q.size()), 32'd100);
        start(8'h03, 1'b1, exp_low);
        wait_done("t5r");
        check_xfer("t5r", 8'h03, exp_low);

        // 6: CPU writes to $4014 during a transfer are ignored
        start(8'h04, 1'b0, exp_low);
        repeat (30) tick();
        cpu_addr = 16'h4014; cpu_d_out = 8'h77; cpu_we = 1'b1;
        repeat (40) tick();
        cpu_we = 1'b0; cpu_d_out = 8'h00;
        wait_done("t6");
        check_xfer("t6", 8'h04, exp_low);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
